// File: rtl/imm_pkg.sv
// Shared constants and entry payload for the pipelined immediate generator.
// Format codes, RV opcode values and the per-entry control payload.
package imm_pkg;

  localparam logic [2:0] FMT_R    = 3'd0;
  localparam logic [2:0] FMT_I    = 3'd1;
  localparam logic [2:0] FMT_S    = 3'd2;
  localparam logic [2:0] FMT_SB   = 3'd3;
  localparam logic [2:0] FMT_U    = 3'd4;
  localparam logic [2:0] FMT_UJ   = 3'd5;
  localparam logic [2:0] FMT_CSRI = 3'd6;
  localparam logic [2:0] FMT_INV  = 3'd7;

  localparam logic [6:0] OPC_LOAD    = 7'b0000011;
  localparam logic [6:0] OPC_OPIMM   = 7'b0010011;
  localparam logic [6:0] OPC_OPIMM32 = 7'b0011011;
  localparam logic [6:0] OPC_STORE   = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH  = 7'b1100011;
  localparam logic [6:0] OPC_JAL     = 7'b1101111;
  localparam logic [6:0] OPC_JALR    = 7'b1100111;
  localparam logic [6:0] OPC_LUI     = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC   = 7'b0010111;
  localparam logic [6:0] OPC_SYSTEM  = 7'b1110011;
  localparam logic [6:0] OPC_OP      = 7'b0110011;
  localparam logic [6:0] OPC_OP32    = 7'b0111011;

  // XLEN-wide imm/pc live beside this struct so the package stays width-agnostic.
  typedef struct packed {
    logic [31:0] inst;
    logic [2:0]  fmt;
    logic        illegal;
    logic        tgt_vld;
  } entry_t;

endpackage

// File: rtl/imm_gen_comb.sv
// Combinational format decode, immediate extraction and illegal-field check.
// Zero latency; no flow control of its own.
module imm_gen_comb
  import imm_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter bit DECODE_FMT = 1'b1
) (
  input  logic [31:0]     inst,
  input  logic [2:0]      fmt_hint,
  output logic [XLEN-1:0] imm,
  output logic [2:0]      fmt,
  output logic            illegal,
  output logic            tgt_vld
);

  logic [6:0]  opc;
  logic [2:0]  f3;
  logic [2:0]  dec_fmt;
  logic        is_shift;
  logic        bad;
  logic [31:0] imm32;

  assign opc = inst[6:0];
  assign f3  = inst[14:12];

  always_comb begin
    dec_fmt = FMT_INV;
    case (opc)
      OPC_LOAD, OPC_OPIMM, OPC_OPIMM32, OPC_JALR: dec_fmt = FMT_I;
      OPC_STORE:                                  dec_fmt = FMT_S;
      OPC_BRANCH:                                 dec_fmt = FMT_SB;
      OPC_LUI, OPC_AUIPC:                         dec_fmt = FMT_U;
      OPC_JAL:                                    dec_fmt = FMT_UJ;
      OPC_SYSTEM:                                 dec_fmt = f3[2] ? FMT_CSRI : FMT_I;
      OPC_OP, OPC_OP32:                           dec_fmt = FMT_R;
      default:                                    dec_fmt = FMT_INV;
    endcase
  end

  assign fmt      = DECODE_FMT ? dec_fmt : fmt_hint;
  assign is_shift = ((opc == OPC_OPIMM) || (opc == OPC_OPIMM32)) && (f3[1:0] == 2'b01);

  // imm32 is built as a 32-bit signed value; zero-extended forms keep bit 31 clear.
  always_comb begin
    imm32 = '0;
    bad   = 1'b0;
    case (fmt)
      FMT_I: begin
        if (is_shift) begin
          if ((XLEN == 64) && (opc == OPC_OPIMM)) begin
            imm32 = {26'b0, inst[25:20]};
          end else begin
            imm32 = {27'b0, inst[24:20]};
            bad   = inst[25];
          end
        end else begin
          imm32 = {{20{inst[31]}}, inst[31:20]};
        end
      end
      FMT_S:    imm32 = {{20{inst[31]}}, inst[31:25], inst[11:7]};
      FMT_SB:   imm32 = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
      FMT_U:    imm32 = {inst[31:12], 12'h000};
      FMT_UJ:   imm32 = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
      FMT_CSRI: imm32 = {27'b0, inst[19:15]};
      FMT_R:    imm32 = '0;
      default:  bad   = 1'b1;
    endcase
    if ((XLEN == 32) && (opc == OPC_OPIMM32)) bad = 1'b1;
  end

  assign imm     = XLEN'($signed(imm32));
  assign illegal = bad;
  assign tgt_vld = (fmt == FMT_SB) || (fmt == FMT_UJ) || ((fmt == FMT_U) && (opc == OPC_AUIPC));

endmodule

// File: rtl/imm_gen_pipe.sv
// Registered immediate generator between IF/ID and ID: 1-cycle latency when output is empty.
// Valid/ready; with SKID a second entry absorbs one transfer under backpressure, else single register.
module imm_gen_pipe
  import imm_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter bit DECODE_FMT = 1'b1,
  parameter bit SKID       = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_inst,
  input  logic [2:0]      in_fmt,
  input  logic [XLEN-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_imm,
  output logic [2:0]      out_fmt,
  output logic [XLEN-1:0] out_target,
  output logic            out_target_vld,
  output logic [XLEN-1:0] out_pc,
  output logic [31:0]     out_inst,
  output logic            out_illegal
);

  logic [XLEN-1:0] c_imm;
  logic [2:0]      c_fmt;
  logic            c_ill;
  logic            c_tv;
  entry_t          c_ent;
  logic            in_fire;

  imm_gen_comb #(.XLEN(XLEN), .DECODE_FMT(DECODE_FMT)) u_comb (
    .inst     (in_inst),
    .fmt_hint (in_fmt),
    .imm      (c_imm),
    .fmt      (c_fmt),
    .illegal  (c_ill),
    .tgt_vld  (c_tv)
  );

  assign c_ent   = '{inst: in_inst, fmt: c_fmt, illegal: c_ill, tgt_vld: c_tv};
  assign in_fire = in_valid && in_ready;

  logic            out_vld_q;
  entry_t          out_ent_q;
  logic [XLEN-1:0] out_imm_q;
  logic [XLEN-1:0] out_pc_q;

  generate
    if (SKID) begin : g_skid
      logic            skid_vld_q;
      logic            rdy_q;
      logic            skid_nxt;
      entry_t          skid_ent_q;
      logic [XLEN-1:0] skid_imm_q;
      logic [XLEN-1:0] skid_pc_q;

      // in_fire implies the skid is empty, so only one of the two terms can be live.
      assign skid_nxt = skid_vld_q ? !out_ready : (in_fire && out_vld_q && !out_ready);
      assign in_ready = rdy_q;

      always_ff @(posedge clk) begin
        if (rst) begin
          out_vld_q  <= 1'b0;
          out_ent_q  <= '0;
          out_imm_q  <= '0;
          out_pc_q   <= '0;
          skid_vld_q <= 1'b0;
          skid_ent_q <= '0;
          skid_imm_q <= '0;
          skid_pc_q  <= '0;
          rdy_q      <= 1'b0;
        end else begin
          if (skid_vld_q && out_ready) begin
            out_ent_q  <= skid_ent_q;
            out_imm_q  <= skid_imm_q;
            out_pc_q   <= skid_pc_q;
            skid_vld_q <= 1'b0;
          end else if (in_fire && (!out_vld_q || out_ready)) begin
            out_vld_q <= 1'b1;
            out_ent_q <= c_ent;
            out_imm_q <= c_imm;
            out_pc_q  <= in_pc;
          end else if (in_fire) begin
            skid_vld_q <= 1'b1;
            skid_ent_q <= c_ent;
            skid_imm_q <= c_imm;
            skid_pc_q  <= in_pc;
          end else if (out_vld_q && out_ready) begin
            out_vld_q <= 1'b0;
          end
          rdy_q <= !skid_nxt;
        end
      end
    end else begin : g_reg
      assign in_ready = !rst && (!out_vld_q || out_ready);

      always_ff @(posedge clk) begin
        if (rst) begin
          out_vld_q <= 1'b0;
          out_ent_q <= '0;
          out_imm_q <= '0;
          out_pc_q  <= '0;
        end else if (in_fire) begin
          out_vld_q <= 1'b1;
          out_ent_q <= c_ent;
          out_imm_q <= c_imm;
          out_pc_q  <= in_pc;
        end else if (out_ready) begin
          out_vld_q <= 1'b0;
        end
      end
    end
  endgenerate

  assign out_valid      = out_vld_q;
  assign out_imm        = out_imm_q;
  assign out_fmt        = out_ent_q.fmt;
  assign out_illegal    = out_ent_q.illegal;
  assign out_target_vld = out_ent_q.tgt_vld;
  assign out_inst       = out_ent_q.inst;
  assign out_pc         = out_pc_q;
  assign out_target     = out_pc_q + out_imm_q;

endmodule
